// File: rtl/flex_counter_updn_pkg.sv
// Shared types for the up/down flex counter: wrap-mode encoding and low-bound helper.
package flex_counter_pkg;

    localparam int WRAP_MODE_W = 2;

    typedef enum logic [WRAP_MODE_W-1:0] {
        WRAP_ONE  = 2'b00,
        WRAP_ZERO = 2'b01,
        SATURATE  = 2'b10,
        WRAP_RSVD = 2'b11
    } wrap_mode_t;

    // Reserved encoding behaves like WRAP_ONE, so only two modes bottom out at 0.
    function automatic logic low_bound_is_zero(input wrap_mode_t mode);
        return (mode == WRAP_ZERO) || (mode == SATURATE);
    endfunction

endpackage

// File: rtl/flex_counter_updn_if.sv
// Control/status bundle of flex_counter_updn; the counter sits on the slave side.
interface flex_counter_updn_if #(
    parameter int SIZE = 4
) ();
    import flex_counter_pkg::*;

    logic            clear;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic            count_enable;
    logic            count_down;
    wrap_mode_t      wrap_mode;
    logic [SIZE-1:0] rollover_val;
    logic [SIZE-1:0] count_out;
    logic            rollover_flag;
    logic            wrap_pulse;

    modport master (
        output clear, load, load_val, count_enable, count_down, wrap_mode, rollover_val,
        input  count_out, rollover_flag, wrap_pulse
    );

    modport slave (
        input  clear, load, load_val, count_enable, count_down, wrap_mode, rollover_val,
        output count_out, rollover_flag, wrap_pulse
    );

endinterface

// File: rtl/flex_counter_updn_prescaler.sv
// Enable prescaler: tick on every (div_val+1)-th enabled cycle; used only with FLEX_COUNTER_PRESCALE_EN.
module flex_prescaler #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [SIZE-1:0] div_val,
    output logic            tick
);

    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] count_d;

    assign tick = en && (count_q == div_val);

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/flex_counter_updn.sv
// Up/down flex counter with load, clear and selectable wrap modes plus a one-cycle wrap pulse.
// Define FLEX_COUNTER_PRESCALE_EN to gate count_enable through a programmable prescaler.
module flex_counter_updn
    import flex_counter_pkg::*;
#(
    parameter int SIZE = 4
`ifdef FLEX_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_SIZE = 8
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef FLEX_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_SIZE-1:0] prescale_val,
`endif
    flex_counter_updn_if.slave       bus
);

    logic [SIZE-1:0] count_q, count_d;
    logic            flag_q, flag_d;
    logic            pulse_q, pulse_d;
    logic [SIZE-1:0] low_bound;
    logic [SIZE-1:0] terminal;
    logic            advance;

`ifdef FLEX_COUNTER_PRESCALE_EN
    flex_prescaler #(
        .SIZE (PRESCALE_SIZE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.clear || bus.load),
        .en      (bus.count_enable),
        .div_val (prescale_val),
        .tick    (advance)
    );
`else
    assign advance = bus.count_enable;
`endif

    assign low_bound = low_bound_is_zero(bus.wrap_mode) ? '0 : SIZE'(1);
    assign terminal  = bus.count_down ? low_bound : bus.rollover_val;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = bus.load_val;
        end else if (advance) begin
            if (!bus.count_down) begin
                // Terminal test precedes +1, so the adder never overflows.
                if (count_q >= bus.rollover_val) begin
                    pulse_d = 1'b1;
                    case (bus.wrap_mode)
                        WRAP_ZERO: count_d = '0;
                        SATURATE:  count_d = count_q;
                        default:   count_d = SIZE'(1);
                    endcase
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q <= low_bound) begin
                    pulse_d = 1'b1;
                    count_d = (bus.wrap_mode == SATURATE) ? count_q : bus.rollover_val;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
        flag_d = (count_d == terminal);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.count_out     = count_q;
    assign bus.rollover_flag = flag_q;
    assign bus.wrap_pulse    = pulse_q;

endmodule
